minirisc_mc_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the MiniRISC core. It replaces single-cycle control with an FSM that owns PC and IR, and performs req/ack handshakes with the instruction and data memories. Memory waits are bounded by a timeout. Decoded control (ALUOp etc.) stays in main_control, fed from the opcode output. The datapath consumes reg_we, pc and ir.

---
 rtl/minirisc_pkg.sv | 28 ++
 rtl/mr_wait_timer.sv | 29 ++
 rtl/minirisc_mc_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_minirisc_mc_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minirisc_pkg.sv
// Shared definitions for the MiniRISC multi-cycle sequencer: FSM state encoding,
// opcode constants, default PC step and a saturating counter helper.
package minirisc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_BR    = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int unsigned PC_STEP_DEFAULT = 4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mr_wait_timer.sv
// Bounded wait counter shared by the FETCH and MEM handshakes; expired flags the
// WAIT_MAX-th consecutive cycle without an acknowledge.
module mr_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(WAIT_MAX - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (waiting) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = waiting && (cnt == LAST);

endmodule

// File: rtl/minirisc_mc_sequencer.sv
// Multi-cycle control sequencer for MiniRISC: owns PC/IR and the imem/dmem req/ack
// handshakes. Define MINIRISC_PERF_CNT_EN to build the cycle/stall perf counters.
module minirisc_mc_sequencer
  import minirisc_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     WAIT_MAX = 15,
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    pc,
  output logic               reg_we,
  output logic [2:0]         state,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        instr_cnt,
  output logic [31:0]        cyc_cnt,
  output logic [31:0]        stall_cnt
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  state_e          state_q;
  logic            br_taken_q;
  logic [PC_W-1:0] br_target_q;
  logic            in_wait;
  logic            cur_ack;
  logic            timeout;
  logic            is_mem;

  assign state     = state_q;
  assign imem_addr = pc;
  assign opcode    = ir[INSTR_W-1 -: 4];
  assign is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign in_wait   = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign cur_ack   = ((state_q == ST_FETCH) && imem_ack) || ((state_q == ST_MEM) && dmem_ack);

  // Clearing on ack as well as outside the wait states guarantees a fresh count on
  // every entry, including the direct MEM(store) -> FETCH hop.
  mr_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait || cur_ack),
    .waiting(in_wait && !cur_ack),
    .expired(timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      reg_we      <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      instr_cnt   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q  <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state_q  <= ST_DECODE;
          end else if (timeout) begin
            imem_req <= 1'b0;
            fault    <= 1'b1;
            state_q  <= ST_FAULT;
          end
        end
        ST_DECODE: begin
          if (opcode == OP_HALT) begin
            halted  <= 1'b1;
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          br_taken_q  <= br_taken;
          br_target_q <= br_target;
          if (is_mem) begin
            dmem_req <= 1'b1;
            dmem_we  <= (opcode == OP_STORE);
            state_q  <= ST_MEM;
          end else if ((opcode == OP_BR) || (opcode == OP_JMP)) begin
            pc        <= br_taken ? br_target : pc + STEP;
            instr_cnt <= sat_inc32(instr_cnt);
            imem_req  <= 1'b1;
            state_q   <= ST_FETCH;
          end else begin
            reg_we  <= 1'b1;
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (opcode == OP_STORE) begin
              pc        <= br_taken_q ? br_target_q : pc + STEP;
              instr_cnt <= sat_inc32(instr_cnt);
              imem_req  <= 1'b1;
              state_q   <= ST_FETCH;
            end else begin
              reg_we  <= 1'b1;
              state_q <= ST_WB;
            end
          end else if (timeout) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            fault    <= 1'b1;
            state_q  <= ST_FAULT;
          end
        end
        ST_WB: begin
          reg_we    <= 1'b0;
          pc        <= br_taken_q ? br_target_q : pc + STEP;
          instr_cnt <= sat_inc32(instr_cnt);
          imem_req  <= 1'b1;
          state_q   <= ST_FETCH;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
      endcase
    end
  end

`ifdef MINIRISC_PERF_CNT_EN
  logic [31:0] cyc_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_FAULT)) begin
        cyc_q <= sat_inc32(cyc_q);
      end
      if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) begin
        stall_q <= sat_inc32(stall_q);
      end
    end
  end

  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
`else
  assign cyc_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_minirisc_mc_sequencer.sv
// Self-checking bench for minirisc_mc_sequencer: directed vector table, corner-case
// sequences and randomized instruction streams against an instruction-level model.
module tb_minirisc_mc_sequencer;

  localparam int unsigned WAIT_MAX = 15;

`ifdef MINIRISC_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk, rst, run;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [31:0] imem_addr, imem_rdata, br_target, ir, pc;
  logic        br_taken, reg_we, halted, fault;
  logic [3:0]  opcode;
  logic [2:0]  state;
  logic [31:0] instr_cnt, cyc_cnt, stall_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;

  minirisc_mc_sequencer #(
    .PC_W    (32),
    .INSTR_W (32),
    .RESET_PC(32'h0),
    .WAIT_MAX(WAIT_MAX),
    .PC_STEP (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .br_taken  (br_taken),
    .br_target (br_target),
    .ir        (ir),
    .opcode    (opcode),
    .pc        (pc),
    .reg_we    (reg_we),
    .state     (state),
    .halted    (halted),
    .fault     (fault),
    .instr_cnt (instr_cnt),
    .cyc_cnt   (cyc_cnt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    int unsigned iw;
    int unsigned dw;
    logic        tk;
    logic [31:0] tgt;
    int unsigned exp_cyc;
    int unsigned exp_we;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  logic [31:0] m_pc, m_icnt, m_cyc, m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = '0; br_taken = 1'b0; br_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step();
  endtask

  task automatic start();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  // Acts as both memories: acks after the requested number of wait cycles and
  // stops once the next fetch begins, or on halt/fault.
  task automatic exec_instr(input logic [31:0] instr, input int unsigned iw, input int unsigned dw,
                            input logic tk, input logic [31:0] tgt,
                            output int unsigned cyc, output int unsigned we, output int unsigned we_bad);
    int unsigned fcnt, mcnt;
    bit was_f, was_m, left_fetch;
    fcnt = 0; mcnt = 0; cyc = 0; we = 0; we_bad = 0; left_fetch = 0;
    br_taken = tk; br_target = tgt; imem_rdata = instr;
    while (cyc < 100) begin
      imem_ack = imem_req && (fcnt == iw);
      dmem_ack = dmem_req && (mcnt == dw);
      if (dmem_req && (dmem_we !== (instr[31:28] == 4'h3))) we_bad++;
      if (reg_we) we++;
      was_f = imem_req; was_m = dmem_req;
      step();
      cyc++;
      if (was_f) fcnt++;
      if (was_m) mcnt++;
      if (!imem_req) left_fetch = 1;
      if ((left_fetch && imem_req) || halted || fault) break;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  function automatic int unsigned model_cycles(input logic [3:0] op, input int unsigned iw, input int unsigned dw);
    int unsigned c;
    c = iw + 1 + 1;
    if (op == 4'hF) return c;
    c += 1;
    if (op == 4'h2 || op == 4'h3) c += dw + 1;
    if (!(op == 4'h4 || op == 4'h6 || op == 4'h3)) c += 1;
    return c;
  endfunction

  function automatic int unsigned model_we(input logic [3:0] op);
    return (op == 4'h4 || op == 4'h6 || op == 4'h3 || op == 4'hF) ? 0 : 1;
  endfunction

  initial begin
    int unsigned cyc, we, we_bad, cnt;
    logic [31:0] instr, pc_hold;
    logic [3:0]  op;
    int unsigned iw, dw;
    logic        tk;
    logic [31:0] tgt;

    vecs[0] = '{4'h0, 0,  0,  1'b0, 32'h0,   4,  1, 32'h4};
    vecs[1] = '{4'h2, 0,  3,  1'b0, 32'h0,   8,  1, 32'h8};
    vecs[2] = '{4'h3, 2,  0,  1'b0, 32'h0,   6,  0, 32'hC};
    vecs[3] = '{4'h4, 0,  0,  1'b1, 32'h100, 3,  0, 32'h100};
    vecs[4] = '{4'h4, 1,  0,  1'b0, 32'h300, 4,  0, 32'h104};
    vecs[5] = '{4'h6, 14, 0,  1'b1, 32'h40,  17, 0, 32'h40};
    vecs[6] = '{4'h1, 5,  0,  1'b0, 32'h0,   9,  1, 32'h44};
    vecs[7] = '{4'h5, 0,  0,  1'b0, 32'h0,   4,  1, 32'h48};
    vecs[8] = '{4'h3, 0,  14, 1'b0, 32'h0,   18, 0, 32'h4C};

    // Reset state
    do_reset();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst_reg_we", {31'd0, reg_we}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_instr_cnt", instr_cnt, 32'd0);
    check("rst_cyc_cnt", cyc_cnt, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);

    repeat (3) step();
    check("idle_hold", {29'd0, state}, 32'd0);
    start();
    check("start_state", {29'd0, state}, 32'd1);
    check("start_imem_req", {31'd0, imem_req}, 32'd1);
    check("start_imem_addr", imem_addr, 32'h0);

    // Directed vector table
    m_cyc = 0; m_stall = 0;
    for (int i = 0; i < 9; i++) begin
      instr = {vecs[i].op, 28'(32'h0ABC_DE0 + i)};
      exec_instr(instr, vecs[i].iw, vecs[i].dw, vecs[i].tk, vecs[i].tgt, cyc, we, we_bad);
      m_cyc += vecs[i].exp_cyc;
      m_stall += vecs[i].iw + ((vecs[i].op == 4'h2 || vecs[i].op == 4'h3) ? vecs[i].dw : 0);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
      check($sformatf("vec%0d_reg_we", i), we, vecs[i].exp_we);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_imem_addr", i), imem_addr, vecs[i].exp_pc);
      check($sformatf("vec%0d_instr_cnt", i), instr_cnt, i + 1);
      check($sformatf("vec%0d_opcode", i), {28'd0, opcode}, {28'd0, vecs[i].op});
      check($sformatf("vec%0d_dmem_we", i), we_bad, 0);
    end
    check("vec_cyc_cnt", cyc_cnt, PERF_ON ? m_cyc : 32'd0);
    check("vec_stall_cnt", stall_cnt, PERF_ON ? m_stall : 32'd0);

    // Reset asserted mid-MEM; late ack after release must be ignored
    br_taken = 1'b0;
    imem_rdata = 32'h2000_0000; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    repeat (2) step();
    check("midmem_req_before", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midmem_req_drop", {31'd0, dmem_req}, 32'd0);
    check("midmem_pc", pc, 32'h0);
    check("midmem_state", {29'd0, state}, 32'd0);
    @(negedge clk) rst = 1'b1;
    dmem_ack = 1'b1;
    repeat (5) step();
    dmem_ack = 1'b0;
    check("late_ack_state", {29'd0, state}, 32'd0);
    check("late_ack_instr_cnt", instr_cnt, 32'd0);
    check("late_ack_dmem_req", {31'd0, dmem_req}, 32'd0);

    // Randomized instruction stream, run dropped right after start
    do_reset();
    start();
    m_pc = 0; m_icnt = 0; m_cyc = 0; m_stall = 0;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(14, 0));
      iw = $urandom_range(WAIT_MAX - 1, 0);
      dw = $urandom_range(WAIT_MAX - 1, 0);
      tk = 1'($urandom_range(1, 0));
      tgt = $urandom() & 32'hFFFF_FFFC;
      instr = {op, 28'($urandom())};
      run = 1'($urandom_range(1, 0));
      exec_instr(instr, iw, dw, tk, tgt, cyc, we, we_bad);
      m_cyc += model_cycles(op, iw, dw);
      m_stall += iw + ((op == 4'h2 || op == 4'h3) ? dw : 0);
      m_pc = tk ? tgt : m_pc + 32'd4;
      m_icnt++;
      check($sformatf("rnd%0d_cycles", n), cyc, model_cycles(op, iw, dw));
      check($sformatf("rnd%0d_reg_we", n), we, model_we(op));
      check($sformatf("rnd%0d_pc", n), pc, m_pc);
      check($sformatf("rnd%0d_instr_cnt", n), instr_cnt, m_icnt);
      check($sformatf("rnd%0d_dmem_we", n), we_bad, 0);
    end
    check("rnd_cyc_cnt", cyc_cnt, PERF_ON ? m_cyc : 32'd0);
    check("rnd_stall_cnt", stall_cnt, PERF_ON ? m_stall : 32'd0);

    // Halt is sticky; pc frozen and run ignored
    pc_hold = pc;
    exec_instr(32'hF000_0000, 2, 0, 1'b1, 32'h800, cyc, we, we_bad);
    check("halt_cycles", cyc, model_cycles(4'hF, 2, 0));
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_state", {29'd0, state}, 32'd6);
    for (int k = 0; k < 8; k++) begin
      run = ~run;
      step();
    end
    check("halt_pc_frozen", pc, pc_hold);
    check("halt_state_hold", {29'd0, state}, 32'd6);
    check("halt_ir_hold", ir, 32'hF000_0000);
    check("halt_instr_cnt", instr_cnt, m_icnt);
    check("halt_imem_req", {31'd0, imem_req}, 32'd0);

    // Fetch timeout: no ack at all
    do_reset();
    start();
    cnt = 0;
    while (!fault && cnt < 40) begin
      step();
      cnt++;
    end
    check("ftimeout_cycles", cnt, WAIT_MAX);
    check("ftimeout_imem_req", {31'd0, imem_req}, 32'd0);
    check("ftimeout_state", {29'd0, state}, 32'd7);
    for (int k = 0; k < 6; k++) begin
      run = ~run;
      imem_ack = 1'b1;
      step();
    end
    imem_ack = 1'b0;
    check("ftimeout_sticky", {31'd0, fault}, 32'd1);
    check("ftimeout_state_hold", {29'd0, state}, 32'd7);
    check("ftimeout_pc_hold", pc, 32'h0);

    // MEM timeout on a load that never gets its ack
    do_reset();
    start();
    exec_instr(32'h2000_0001, 0, 1000, 1'b0, 32'h0, cyc, we, we_bad);
    check("mtimeout_cycles", cyc, 3 + WAIT_MAX);
    check("mtimeout_fault", {31'd0, fault}, 32'd1);
    check("mtimeout_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("mtimeout_reg_we", we, 0);
    check("mtimeout_instr_cnt", instr_cnt, 32'd0);
    do_reset();
    check("fault_cleared", {31'd0, fault}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
